// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel-RAM read port and ws2812 encoder bit port of the frame sequencer.
// Build option: WS2812_RGBW_EN selects 32-bit {G,R,B,W} pixel words; the default is 24-bit {G,R,B}.
// master = frame sequencer, slave = pixel RAM plus encoder.
interface ws2812_frame_ctrl_if #(
    parameter int ADDR_W = 8
);
`ifdef WS2812_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PW-1:0]     rd_data;
    logic              bit_data;
    logic              bit_le;
    logic              bit_done;

    modport master (
        output rd_en, rd_addr, bit_data, bit_le,
        input  rd_data, bit_done
    );

    modport slave (
        input  rd_en, rd_addr, bit_data, bit_le,
        output rd_data, bit_done
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// ws2812 frame sequencer: fetches NUM_LEDS pixel words from a synchronous RAM, shifts each
// word MSB-first into the single-bit encoder (one bit per bit_le/bit_done handshake), then
// holds the line low for RESET_CYCLES so the strip latches, and pulses frame_done.
// Build option: WS2812_RGBW_EN widens pixel words to 32 bits ({G,R,B,W}); default is 24 bits.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS     = 64,
    parameter int ADDR_W       = 8,
    parameter int RESET_CYCLES = 60000,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                Rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                frame_done_o,
    ws2812_frame_ctrl_if.master bus
);
`ifdef WS2812_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif
    localparam int                BC_W     = $clog2(PW);
    localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(PW - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT, S_LATCH
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              abort_pend_q, abort_pend_d;
    logic              wait_arm_q, wait_arm_d;
    logic              frame_done_q, frame_done_d;

    logic start_ok;
    logic bit_done_ok;
    logic lat_last;
    logic bit_step;
    logic pix_step;

    // A start coinciding with the frame_done pulse is dropped so frames never run back to back.
    assign start_ok    = (state_q == S_IDLE) && start_i && !frame_done_q;
    // The first WAIT cycle ignores bit_done: the encoder only samples indata one clk after bit_le.
    assign bit_done_ok = (state_q == S_WAIT) && wait_arm_q && bus.bit_done;
    assign lat_last    = (state_q == S_LATCH) && (lat_cnt_q == LAT_LAST);
    assign bit_step    = bit_done_ok && !abort_pend_q && (bit_cnt_q != '0);
    assign pix_step    = bit_done_ok && !abort_pend_q && (bit_cnt_q == '0) && (pix_idx_q != PIX_LAST);

    // State register.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_SEND;
            S_SEND:  state_d = S_WAIT;
            S_WAIT: begin
                if (bit_done_ok) begin
                    if (abort_pend_q)   state_d = S_LATCH;
                    else if (bit_step)  state_d = S_SEND;
                    else if (pix_step)  state_d = S_FETCH;
                    else                state_d = S_LATCH;
                end
            end
            S_LATCH: if (lat_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: pixel index, bit counter, shift register, latch counter, abort flag.
    always_comb begin
        pix_idx_d    = pix_idx_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        lat_cnt_d    = '0;
        abort_pend_d = abort_pend_q;
        wait_arm_d   = (state_q == S_WAIT);
        frame_done_d = lat_last;

        if (start_ok) pix_idx_d = '0;
        if (pix_step) pix_idx_d = pix_idx_q + ADDR_W'(1);

        if (state_q == S_LOAD) begin
            shreg_d   = bus.rd_data;
            bit_cnt_d = BIT_LAST;
        end
        if (bit_step) begin
            shreg_d   = {shreg_q[PW-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BC_W'(1);
        end

        if ((state_q == S_LATCH) && !lat_last) lat_cnt_d = lat_cnt_q + CNT_W'(1);

        // Abort is only remembered while a frame is being fetched or sent; the bit in flight
        // always finishes before the line goes to LATCH.
        if (abort_i && (state_q inside {S_FETCH, S_LOAD, S_SEND, S_WAIT})) abort_pend_d = 1'b1;
        if (lat_last) abort_pend_d = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pix_idx_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            lat_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            wait_arm_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pix_idx_q    <= pix_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            lat_cnt_q    <= lat_cnt_d;
            abort_pend_q <= abort_pend_d;
            wait_arm_q   <= wait_arm_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs decoded from state; bit_data stays on the shift-register MSB through SEND and WAIT.
    always_comb begin
        bus.rd_en    = (state_q == S_FETCH);
        bus.rd_addr  = pix_idx_q;
        bus.bit_le   = (state_q == S_SEND);
        bus.bit_data = ((state_q == S_SEND) || (state_q == S_WAIT)) ? shreg_q[PW-1] : 1'b0;
        busy_o       = (state_q != S_IDLE);
        frame_done_o = frame_done_q;
    end
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Testbench for ws2812_frame_ctrl: two instances (NUM_LEDS=1 and NUM_LEDS=3) with a 1-clk RAM
// model and an encoder model returning bit_done 340 clk after each bit_le.
// Build option WS2812_RGBW_EN switches the pixel words to 32 bits.
module tb_ws2812_frame_ctrl;
    localparam int AW      = 8;
    localparam int RC      = 40;
    localparam int CW      = 8;
    localparam int ENC_LAT = 339;
`ifdef WS2812_RGBW_EN
    localparam int PW = 32;
    localparam logic [PW-1:0] W_A   = 32'h0000_00FF;
    localparam logic [PW-1:0] EXP_A = 32'b0000_0000_0000_0000_0000_0000_1111_1111;
`else
    localparam int PW = 24;
    localparam logic [PW-1:0] W_A   = 24'hA5_0F_81;
    localparam logic [PW-1:0] EXP_A = 24'b1010_0101_0000_1111_1000_0001;
`endif
    localparam logic [PW-1:0] W_F = '1;
    localparam logic [PW-1:0] W_Z = '0;
    localparam logic [PW-1:0] W_M = {1'b1, {(PW-2){1'b0}}, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n [2];
    logic start_s [2];
    logic abort_s [2];
    logic bd_extra [2];
    logic busy_w [2];
    logic frame_done_w [2];
    logic rd_en_w [2];
    logic bit_le_w [2];
    logic bit_data_w [2];
    logic [AW-1:0] rd_addr_w [2];
    logic [PW-1:0] rd_data_m [2];
    logic bit_done_m [2] = '{1'b0, 1'b0};
    logic [PW-1:0] ram [2][4];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ws2812_frame_ctrl_if #(.ADDR_W(AW)) bus ();
        ws2812_frame_ctrl #(
            .NUM_LEDS(gi == 0 ? 1 : 3), .ADDR_W(AW), .RESET_CYCLES(RC), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .Rst_n(rst_n[gi]), .start_i(start_s[gi]), .abort_i(abort_s[gi]),
            .busy_o(busy_w[gi]), .frame_done_o(frame_done_w[gi]), .bus(bus.master)
        );
        assign bus.rd_data      = rd_data_m[gi];
        assign bus.bit_done     = bit_done_m[gi] | bd_extra[gi];
        assign rd_en_w[gi]      = bus.rd_en;
        assign rd_addr_w[gi]    = bus.rd_addr;
        assign bit_le_w[gi]     = bus.bit_le;
        assign bit_data_w[gi]   = bus.bit_data;
    end

    // RAM model, encoder model and event monitor for both instances.
    longint      cyc = 0;
    int          le_cnt [2] = '{0, 0};
    int          bd_cnt [2] = '{0, 0};
    int          fd_cnt [2] = '{0, 0};
    int          overlap [2] = '{0, 0};
    int          hold_err [2] = '{0, 0};
    int          enc_cnt [2] = '{0, 0};
    logic        samp_q [2] = '{1'b0, 1'b0};
    logic [95:0] bits_log [2] = '{96'd0, 96'd0};
    logic [15:0] addr_log [2] = '{16'd0, 16'd0};
    longint      last_bd_cyc [2] = '{0, 0};
    longint      fd_cyc [2] = '{0, 0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rd_en_w[k]) begin
                rd_data_m[k] <= ram[k][rd_addr_w[k][1:0]];
                addr_log[k]  <= {addr_log[k][11:0], rd_addr_w[k][3:0]};
            end
            samp_q[k] <= bit_le_w[k];
            if (samp_q[k]) bits_log[k] <= {bits_log[k][94:0], bit_data_w[k]};
            if (frame_done_w[k]) begin
                fd_cnt[k] <= fd_cnt[k] + 1;
                fd_cyc[k] <= cyc;
            end
            if (!rst_n[k]) begin
                enc_cnt[k]    <= 0;
                bit_done_m[k] <= 1'b0;
            end else begin
                bit_done_m[k] <= 1'b0;
                if (bit_le_w[k]) begin
                    le_cnt[k] <= le_cnt[k] + 1;
                    if (enc_cnt[k] != 0) overlap[k] <= overlap[k] + 1;
                    enc_cnt[k] <= ENC_LAT;
                end else if (enc_cnt[k] != 0) begin
                    enc_cnt[k] <= enc_cnt[k] - 1;
                    if (enc_cnt[k] == 1) bit_done_m[k] <= 1'b1;
                end
                if (bit_done_m[k]) begin
                    bd_cnt[k]      <= bd_cnt[k] + 1;
                    last_bd_cyc[k] <= cyc;
                    if (bit_data_w[k] !== bits_log[k][0]) hold_err[k] <= hold_err[k] + 1;
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bits(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          d;
        int          start_bit;
        bit          start_latch;
        bit          abort_start;
        int          abort_bit;
        bit          abort_latch;
        int          exp_le;
        logic [95:0] exp_bits;
        int          exp_addr_n;
        logic [15:0] exp_addr;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    initial begin
        #9_900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        int          d, le0, bd0, fd0, ov0, he0, lat, t3, tl, n, budget;
        bit          s_done;
        logic [95:0] mask;
        logic [15:0] amask;

        // d, start_bit, start_latch, abort_start, abort_bit, abort_latch, exp_le, bits, addr_n, addr
        vecs[0] = '{0, -1, 1'b0, 1'b0, 0, 1'b0, PW,     96'(EXP_A),            1, 16'h0000};
        vecs[1] = '{1, -1, 1'b0, 1'b0, 0, 1'b0, 3 * PW, 96'({W_F, W_Z, W_M}),  3, 16'h0012};
        vecs[2] = '{0,  5, 1'b1, 1'b0, 0, 1'b0, PW,     96'(EXP_A),            1, 16'h0000};
        vecs[3] = '{1, -1, 1'b0, 1'b0, 3, 1'b1, 3,      96'(3'b111),           1, 16'h0000};
        vecs[4] = '{0, -1, 1'b0, 1'b1, 0, 1'b0, PW,     96'(EXP_A),            1, 16'h0000};

        ram[0][0] = W_A; ram[0][1] = '0; ram[0][2] = '0; ram[0][3] = '0;
        ram[1][0] = W_F; ram[1][1] = W_Z; ram[1][2] = W_M; ram[1][3] = '0;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b1; start_s[k] = 1'b0; abort_s[k] = 1'b0; bd_extra[k] = 1'b0;
        end

        // Reset: every output low while Rst_n is held.
        #3;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset outputs dut%0d", k),
                  {busy_w[k], frame_done_w[k], bit_le_w[k], rd_en_w[k], bit_data_w[k], rd_addr_w[k]}, 0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // bit_done and abort in IDLE are ignored (a stuck abort would truncate vector 0).
        le0 = le_cnt[0];
        bd_extra[0] = 1'b1; abort_s[0] = 1'b1;
        @(negedge clk);
        bd_extra[0] = 1'b0; abort_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("idle bit_done/abort busy", busy_w[0], 0);
        check("idle bit_done/abort bit_le", le_cnt[0] - le0, 0);
        $display("idle poke: busy=%0d bit_le=%0d", busy_w[0], le_cnt[0] - le0);

        // Table-driven frames.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i]; d = v.d;
            le0 = le_cnt[d]; bd0 = bd_cnt[d]; fd0 = fd_cnt[d]; ov0 = overlap[d]; he0 = hold_err[d];
            budget = v.exp_le * 350 + RC + 200;
            @(negedge clk);
            start_s[d] = 1'b1; abort_s[d] = v.abort_start;
            @(negedge clk);
            start_s[d] = 1'b0; abort_s[d] = 1'b0;
            lat = 1;
            while (!bit_le_w[d] && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d first bit_le latency", i), lat, 3);
            t3 = -1; tl = -1; s_done = 1'b0;
            for (int t = 0; t < budget && fd_cnt[d] == fd0; t++) begin
                @(negedge clk);
                start_s[d] = 1'b0; abort_s[d] = 1'b0;
                if (v.start_bit >= 0 && !s_done && (le_cnt[d] - le0) == v.start_bit) begin
                    start_s[d] = 1'b1; s_done = 1'b1;
                end
                if (v.abort_bit > 0 && t3 < 0 && (le_cnt[d] - le0) == v.abort_bit) t3 = t;
                if (t3 >= 0 && t == t3 + 10) abort_s[d] = 1'b1;
                if (tl < 0 && (bd_cnt[d] - bd0) == v.exp_le) tl = t;
                if (tl >= 0 && t == tl + 5) begin
                    start_s[d] = v.start_latch; abort_s[d] = v.abort_latch;
                end
            end
            @(negedge clk);
            start_s[d] = 1'b0; abort_s[d] = 1'b0;
            repeat (5) @(negedge clk);
            mask  = {96{1'b1}} >> (96 - v.exp_le);
            amask = 16'hFFFF >> (16 - 4 * v.exp_addr_n);
            check($sformatf("v%0d bit_le count", i), le_cnt[d] - le0, v.exp_le);
            check($sformatf("v%0d bit_done count", i), bd_cnt[d] - bd0, v.exp_le);
            check($sformatf("v%0d frame_done count", i), fd_cnt[d] - fd0, 1);
            check($sformatf("v%0d busy after frame", i), busy_w[d], 0);
            check($sformatf("v%0d latch gap", i), fd_cyc[d] - last_bd_cyc[d], RC + 1);
            check($sformatf("v%0d bit_le overlap", i), overlap[d] - ov0, 0);
            check($sformatf("v%0d bit_data hold", i), hold_err[d] - he0, 0);
            check_bits($sformatf("v%0d bit stream", i), bits_log[d] & mask, v.exp_bits & mask);
            check_bits($sformatf("v%0d rd_addr seq", i), 96'(addr_log[d] & amask), 96'(v.exp_addr & amask));
            $display("vec %0d dut%0d: bit_le=%0d frame_done=%0d bits=%h latch_gap=%0d",
                     i, d, le_cnt[d] - le0, fd_cnt[d] - fd0, bits_log[d] & mask,
                     fd_cyc[d] - last_bd_cyc[d]);
        end

        // start in the frame_done cycle is dropped, start one clk later is taken; abort in FETCH
        // still lets one bit out.
        le0 = le_cnt[0];
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0; abort_s[0] = 1'b1;
        @(negedge clk); abort_s[0] = 1'b0;
        n = 0;
        while (!frame_done_w[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("fetch abort frame_done seen", frame_done_w[0], 1);
        check("fetch abort bit_le count", le_cnt[0] - le0, 1);
        start_s[0] = 1'b1;
        @(negedge clk);
        check("start with frame_done dropped", busy_w[0], 0);
        @(negedge clk);
        start_s[0] = 1'b0;
        check("start 1 clk after frame_done taken", busy_w[0], 1);
        abort_s[0] = 1'b1;
        @(negedge clk); abort_s[0] = 1'b0;
        n = 0;
        while (!frame_done_w[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("second short frame done", frame_done_w[0], 1);
        check("second short frame bit_le", le_cnt[0] - le0, 2);
        $display("frame_done boundary: bit_le=%0d", le_cnt[0] - le0);

        // Reset in WAIT of the second pixel, then restart from pixel 0.
        ram[1][1] = W_A;
        repeat (3) @(negedge clk);
        le0 = le_cnt[1];
        start_s[1] = 1'b1;
        @(negedge clk); start_s[1] = 1'b0;
        n = 0;
        while ((le_cnt[1] - le0) < PW + 1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("pre-reset busy", busy_w[1], 1);
        rst_n[1] = 1'b0;
        #1;
        check("mid-frame reset outputs",
              {bit_le_w[1], rd_en_w[1], busy_w[1], bit_data_w[1], frame_done_w[1], rd_addr_w[1]}, 0);
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);
        le0 = le_cnt[1]; fd0 = fd_cnt[1];
        start_s[1] = 1'b1;
        @(negedge clk); start_s[1] = 1'b0;
        check("restart rd_en", rd_en_w[1], 1);
        check("restart rd_addr", rd_addr_w[1], 0);
        n = 0;
        while ((le_cnt[1] - le0) < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        abort_s[1] = 1'b1;
        @(negedge clk); abort_s[1] = 1'b0;
        n = 0;
        while (fd_cnt[1] == fd0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("restart frame_done", fd_cnt[1] - fd0, 1);
        check("restart bit_le count", le_cnt[1] - le0, 3);
        check_bits("restart bits from pixel 0", bits_log[1] & 96'h7, 96'h7);
        $display("reset/restart: bit_le=%0d bits=%b", le_cnt[1] - le0, bits_log[1][2:0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
